// File: rtl/pixel_draw_engine.sv
// Rasterises held draw commands (floors, man sprite, man erase) into a stream of
// VGA pixel writes, pulsing a per-command finish flag on the final pixel.
module pixel_draw_engine #(
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter int          MAN_W        = 8,
  parameter int          MAN_H        = 16,
  parameter int          NUM_FLOORS   = 3,
  parameter int          FLOOR_Y0     = 39,
  parameter int          FLOOR_PITCH  = 40,
  parameter logic [2:0]  FLOOR_COLOUR = 3'b100,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       drawing_floors,
  input  logic       draw_man,
  input  logic       erase,
  input  logic [7:0] man_x,
  input  logic [6:0] man_y,
  input  logic [1:0] man_style,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       draw_floors_finish,
  output logic       drawing_man_finish,
  output logic       erase_finish,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, FLOORS, MAN, ERASE, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] dx_q, dx_d;
  logic [3:0] dy_q, dy_d;
  logic [1:0] fk_q, fk_d;
  logic [7:0] ox_q, ox_d;
  logic [6:0] oy_q, oy_d;
  logic [1:0] style_q, style_d;

  logic       lastMan, lastFloor, manActive, onScreen;
  logic [8:0] sumX;
  logic [7:0] sumY;
  logic [6:0] floorRow;
  logic [2:0] manColour;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      fk_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      style_q <= '0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      fk_q    <= fk_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      style_q <= style_d;
    end
  end

  assign lastMan   = (dx_q == 8'(MAN_W - 1)) && (dy_q == 4'(MAN_H - 1));
  assign lastFloor = (dx_q == 8'(SCREEN_W - 1)) && (fk_q == 2'(NUM_FLOORS - 1));
  assign manActive = (state_q == MAN) ? draw_man : erase;

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    fk_d    = fk_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    style_d = style_q;
    case (state_q)
      IDLE: begin
        if (drawing_floors || erase || draw_man) begin
          ox_d    = man_x;
          oy_d    = man_y;
          style_d = man_style;
          dx_d    = '0;
          dy_d    = '0;
          fk_d    = '0;
          if (drawing_floors)  state_d = FLOORS;
          else if (erase)      state_d = ERASE;
          else                 state_d = MAN;
        end
      end
      FLOORS: begin
        if (!drawing_floors) begin
          state_d = IDLE;
        end else if (lastFloor) begin
          state_d = DONE;
        end else if (dx_q == 8'(SCREEN_W - 1)) begin
          dx_d = '0;
          fk_d = fk_q + 2'd1;
        end else begin
          dx_d = dx_q + 8'd1;
        end
      end
      MAN, ERASE: begin
        if (!manActive) begin
          state_d = IDLE;
        end else if (lastMan) begin
          state_d = DONE;
        end else if (dx_q == 8'(MAN_W - 1)) begin
          dx_d = '0;
          dy_d = dy_q + 4'd1;
        end else begin
          dx_d = dx_q + 8'd1;
        end
      end
      DONE: begin
        // A held command must drop before anything new is accepted.
        if (!drawing_floors && !erase && !draw_man) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sumX     = {1'b0, ox_q} + {1'b0, dx_q};
  assign sumY     = {1'b0, oy_q} + {4'b0, dy_q};
  assign onScreen = (sumX < 9'(SCREEN_W)) && (sumY < 8'(SCREEN_H));
  assign floorRow = 7'(FLOOR_Y0) + 7'(fk_q) * 7'(FLOOR_PITCH);

  always_comb begin
    case (style_q)
      2'd0:    manColour = 3'b111;
      2'd1:    manColour = 3'b110;
      2'd2:    manColour = 3'b011;
      default: manColour = 3'b010;
    endcase
  end

  always_comb begin
    x                  = '0;
    y                  = '0;
    colour             = '0;
    plot               = 1'b0;
    draw_floors_finish = 1'b0;
    drawing_man_finish = 1'b0;
    erase_finish       = 1'b0;
    case (state_q)
      FLOORS: begin
        x                  = dx_q;
        y                  = floorRow;
        colour             = FLOOR_COLOUR;
        plot               = 1'b1;
        draw_floors_finish = lastFloor;
      end
      MAN: begin
        x                  = sumX[7:0];
        y                  = sumY[6:0];
        colour             = manColour;
        plot               = onScreen;
        drawing_man_finish = lastMan;
      end
      ERASE: begin
        x            = sumX[7:0];
        y            = sumY[6:0];
        colour       = BG_COLOUR;
        plot         = onScreen;
        erase_finish = lastMan;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_draw_engine.sv
// Randomised bench for pixel_draw_engine: each command's expected pixel stream is
// built as a list from the drawing rules and compared cycle by cycle.
module tb_pixel_draw_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       drawing_floors = 1'b0, draw_man = 1'b0, erase = 1'b0;
  logic [7:0] man_x = '0;
  logic [6:0] man_y = '0;
  logic [1:0] man_style = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, draw_floors_finish, drawing_man_finish, erase_finish, busy;

  int checks = 0;
  int errors = 0;

  int expP[$], expX[$], expY[$], expC[$], expF[$];

  pixel_draw_engine dut (
    .clk(clk), .reset_n(reset_n),
    .drawing_floors(drawing_floors), .draw_man(draw_man), .erase(erase),
    .man_x(man_x), .man_y(man_y), .man_style(man_style),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .draw_floors_finish(draw_floors_finish), .drawing_man_finish(drawing_man_finish),
    .erase_finish(erase_finish), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // kind: 0 = floors, 1 = erase, 2 = man
  function automatic void buildModel(input int kind, input int ox, input int oy, input int st);
    int manCol[4];
    int sx, sy;
    manCol = '{7, 6, 3, 2};
    expP.delete(); expX.delete(); expY.delete(); expC.delete(); expF.delete();
    if (kind == 0) begin
      for (int fk = 0; fk < 3; fk++)
        for (int dx = 0; dx < 160; dx++) begin
          expP.push_back(1);
          expX.push_back(dx);
          expY.push_back(39 + 40 * fk);
          expC.push_back(4);
          expF.push_back((fk == 2 && dx == 159) ? 1 : 0);
        end
    end else begin
      for (int dy = 0; dy < 16; dy++)
        for (int dx = 0; dx < 8; dx++) begin
          sx = ox + dx;
          sy = oy + dy;
          expP.push_back((sx < 160 && sy < 120) ? 1 : 0);
          expX.push_back(sx % 256);
          expY.push_back(sy % 128);
          expC.push_back(kind == 1 ? 0 : manCol[st]);
          expF.push_back((dx == 7 && dy == 15) ? 1 : 0);
        end
    end
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "Plot"}, plot, 0);
    checkOutput({tag, "FloorsFin"}, draw_floors_finish, 0);
    checkOutput({tag, "ManFin"}, drawing_man_finish, 0);
    checkOutput({tag, "EraseFin"}, erase_finish, 0);
  endtask

  // cmdMask bits: [2] floors, [1] erase, [0] man. abortAt < 0 runs to completion.
  task automatic applyStimulus(input logic [2:0] cmdMask, input int ox, input int oy, input int st,
                               input int abortAt, input int holdAfter, input logic [2:0] lateMask);
    int kind, n, plots, expPlots;
    kind = cmdMask[2] ? 0 : (cmdMask[1] ? 1 : 2);
    buildModel(kind, ox, oy, st);
    n = expP.size();
    plots = 0;
    expPlots = 0;
    @(negedge clk);
    man_x = 8'(ox); man_y = 7'(oy); man_style = 2'(st);
    {drawing_floors, erase, draw_man} = cmdMask;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("plot", plot, expP[i]);
      checkOutput("busy", busy, 1);
      if (expP[i] == 1) begin
        checkOutput("x", x, expX[i]);
        checkOutput("y", y, expY[i]);
        checkOutput("colour", colour, expC[i]);
      end
      checkOutput("floorsFin", draw_floors_finish, (kind == 0) ? expF[i] : 0);
      checkOutput("eraseFin", erase_finish, (kind == 1) ? expF[i] : 0);
      checkOutput("manFin", drawing_man_finish, (kind == 2) ? expF[i] : 0);
      plots += plot ? 1 : 0;
      expPlots += expP[i];
      if (i == 0) begin
        man_x = 8'($urandom);
        man_y = 7'($urandom);
        man_style = 2'($urandom);
        {drawing_floors, erase, draw_man} = {drawing_floors, erase, draw_man} | lateMask;
      end
      if (i == abortAt) begin
        {drawing_floors, erase, draw_man} = 3'b000;
        @(negedge clk);
        checkIdleOutputs("abort");
        checkOutput("abortBusy", busy, 0);
        return;
      end
    end
    checkOutput("plotCount", plots, expPlots);
    for (int h = 0; h <= holdAfter; h++) begin
      @(negedge clk);
      checkIdleOutputs("done");
      checkOutput("doneBusy", busy, 1);
    end
    {drawing_floors, erase, draw_man} = 3'b000;
    @(negedge clk);
    checkIdleOutputs("idle");
    checkOutput("idleBusy", busy, 0);
  endtask

  task automatic resetMidRaster();
    @(negedge clk);
    man_x = 8'd30; man_y = 7'd40; man_style = 2'd1;
    draw_man = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkIdleOutputs("asyncRst");
    checkOutput("asyncRstX", x, 0);
    checkOutput("asyncRstY", y, 0);
    checkOutput("asyncRstColour", colour, 0);
    checkOutput("asyncRstBusy", busy, 0);
    draw_man = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstBusy", busy, 0);
    checkOutput("postRstPlot", plot, 0);
  endtask

  initial begin
    logic [2:0] mask;
    int abortAt;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetX", x, 0);
    checkOutput("resetY", y, 0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idleBusy0", busy, 0);

    resetMidRaster();
    applyStimulus(3'b001, 10, 20, 2, -1, 0, 3'b000);
    applyStimulus(3'b101, 0, 0, 0, -1, 0, 3'b000);
    applyStimulus(3'b001, 50, 60, 0, -1, 4, 3'b000);
    applyStimulus(3'b001, 50, 60, 3, -1, 0, 3'b100);
    applyStimulus(3'b010, 156, 110, 1, -1, 0, 3'b001);
    applyStimulus(3'b010, 40, 30, 0, 49, 0, 3'b000);
    applyStimulus(3'b010, 40, 30, 0, -1, 0, 3'b000);
    applyStimulus(3'b100, 0, 0, 0, 200, 0, 3'b011);

    for (int r = 0; r < 8; r++) begin
      mask = 3'($urandom_range(1, 7));
      abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : -1;
      applyStimulus(mask, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 3)), abortAt, int'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_draw_engine.md
Name: pixel_draw_engine

Overview:
- Datapath responder to the game controller FSM. It accepts level-held draw commands (floors, man, erase) and rasterises each one into a stream of (x, y, colour, plot) pixel writes toward the VGA adapter.
- Returns a one-cycle finish flag per command on the final pixel.
- Sits between the controller FSM and the VGA adapter. Its plot output gates the adapter write enable.

Parameters:
- SCREEN_W, 160, visible columns; x range 0..159.
- SCREEN_H, 120, visible rows; y range 0..119.
- MAN_W, 8, man sprite width in pixels.
- MAN_H, 16, man sprite height in pixels.
- NUM_FLOORS, 3, number of horizontal floor lines.
- FLOOR_Y0, 39, row of floor 0.
- FLOOR_PITCH, 40, row spacing between floors.
- FLOOR_COLOUR, 3'b100, floor colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- drawing_floors  in  1  floor-draw command, held high until finish
- draw_man  in  1  man-draw command, held high until finish
- erase  in  1  man-erase command, held high until finish
- man_x  in  8  man left column, sampled at command accept
- man_y  in  7  man top row, sampled at command accept
- man_style  in  2  man colour select, sampled at command accept
- x  out  8  pixel column
- y  out  7  pixel row
- colour  out  3  pixel colour
- plot  out  1  pixel valid (write strobe)
- draw_floors_finish  out  1  last floor pixel this cycle
- drawing_man_finish  out  1  last man pixel this cycle
- erase_finish  out  1  last erase pixel this cycle
- busy  out  1  high in any non-IDLE state

Behaviour:
- Reset is asynchronous, active-low. It forces state IDLE, all counters and captured origin/style to 0, and x=0, y=0, colour=0, plot=0, all finish=0, busy=0.
- All outputs decode from registered state only; there is no combinational input-to-output path.
- States: IDLE, FLOORS, MAN, ERASE, DONE.
- IDLE: when any command is high, accept one and enter its state. Priority is drawing_floors > erase > draw_man.
  - On accept: capture man_x, man_y, man_style; clear dx, dy, fk.
  - The first pixel is presented the cycle after the command is first seen high (1-cycle latency).
- MAN: dx counts 0..MAN_W-1 (inner loop), dy counts 0..MAN_H-1 (outer loop).
  - x = ox+dx, y = oy+dy.
  - colour by style: 0 -> 3'b111, 1 -> 3'b110, 2 -> 3'b011, 3 -> 3'b010.
  - 128 pixel cycles total.
- ERASE: same raster as MAN, colour = BG_COLOUR.
- FLOORS: dx counts 0..SCREEN_W-1, fk counts 0..NUM_FLOORS-1.
  - x = dx, y = FLOOR_Y0 + fk*FLOOR_PITCH, colour = FLOOR_COLOUR.
  - 480 pixel cycles total.
- The finish flag for the active command is high exactly in the cycle presenting the last pixel (dx, dy or fk at max). Next state is DONE.
- DONE: plot=0, no finish. Return to IDLE once all three commands are low. A still-held command is never re-accepted without first dropping.
- Clipping: sums are computed 9-bit/8-bit. If ox+dx >= SCREEN_W or oy+dy >= SCREEN_H, plot=0 for that pixel, but the counters still advance. Cycle count and finish timing are unchanged; x/y outputs carry the truncated low bits.
- Command dropped mid-raster (active command low): abort to IDLE next cycle, plot=0, no finish pulse.
- A different command raised mid-raster is ignored until return to IDLE.
- Inputs man_x, man_y, man_style changing mid-raster have no effect; only the captured values are used.
- plot=1 only in FLOORS/MAN/ERASE for in-screen pixels.

Test Plan:
- Reset: assert reset_n=0 mid-MAN raster (async, between edges) -> all outputs 0 immediately, state IDLE. After release, busy=0.
- Man draw: man_x=10, man_y=20, style=2, draw_man held -> first pixel (10,20,3'b011) one cycle after accept. 128 plot cycles. Last pixel (17,35) coincides with drawing_man_finish=1 for 1 cycle. plot=0 next cycle.
- Floors: drawing_floors held -> 480 plot cycles. Rows 39, 79, 119 with x 0..159, colour 3'b100. draw_floors_finish exactly at (159,119).
- Clipping: man_x=156, man_y=110, erase held -> 128 cycles still elapse and erase_finish fires on cycle 128. plot=0 for dx>=4 or dy>=10, so 40 plotted pixels total, all colour 3'b000.
- Priority and held command: drawing_floors and draw_man raised together -> floors raster runs. With draw_man kept high after finish -> DONE holds, plot=0, until all commands low for 1 cycle. Re-raising draw_man is then accepted.
- Abort: drop erase after 50 pixels -> plot=0 next cycle, no erase_finish, IDLE. A fresh erase then restarts at dx=dy=0.
